// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer: captures de-skewed psum rows from the systolic array,
// accumulates them over several K-passes into an on-chip row buffer, then
// drains the accumulated rows over a valid/ready handshake.
// Optional feature macro: OUTPUT_ACCUM_RELU_EN (clamps negative output lanes
// to zero on the drain path; stored accumulators keep their signed value).
module psum_accum_buffer #(
   parameter int PSUM_WIDTH  = 32,
   parameter int ARRAY_WIDTH = 4,
   parameter int ACC_WIDTH   = 40,
   parameter int DEPTH       = 16,
   parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   num_rows,
   input  logic [7:0]            num_passes,
   input  logic                  psum_valid,
   input  logic [PSUM_WIDTH-1:0] psum_in [ARRAY_WIDTH],
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_data [ARRAY_WIDTH],
   output logic                  out_last,
   output logic                  done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                                 state_r;
   state_t                                 state_nx_s;
   logic [ADDR_WIDTH-1:0]                  row_ptr_r;
   logic [ADDR_WIDTH-1:0]                  rd_ptr_r;
   logic [ADDR_WIDTH-1:0]                  rd_next_s;
   logic [7:0]                             pass_cnt_r;
   logic [7:0]                             passes_r;
   logic [ADDR_WIDTH:0]                    rows_r;
   logic [ARRAY_WIDTH-1:0][ACC_WIDTH-1:0]  mem_r [DEPTH];
   logic [ARRAY_WIDTH-1:0][ACC_WIDTH-1:0]  sext_s;
   logic [ARRAY_WIDTH-1:0][ACC_WIDTH-1:0]  wr_row_s;
   logic [ARRAY_WIDTH-1:0][ACC_WIDTH-1:0]  row0_s;
   logic                                   accept_s;
   logic                                   row_wrap_s;
   logic                                   last_pass_s;
   logic                                   final_write_s;
   logic                                   drain_hs_s;
   logic                                   zero_start_s;

   // Output-path clamp; only the drained copy is affected, never the buffer.
   function automatic logic [ACC_WIDTH-1:0] relu_lane(input logic [ACC_WIDTH-1:0] v);
`ifdef OUTPUT_ACCUM_RELU_EN
      if (v[ACC_WIDTH-1]) begin
         relu_lane = {ACC_WIDTH{1'b0}};
      end else begin
         relu_lane = v;
      end
`else
      relu_lane = v;
`endif
   endfunction

   // Row write value: pass 0 overwrites, later passes add (wraps mod 2^ACC_WIDTH).
   always_comb begin
      sext_s   = '{default: {ACC_WIDTH{1'b0}}};
      wr_row_s = '{default: {ACC_WIDTH{1'b0}}};
      for (int i = 0; i < ARRAY_WIDTH; i++) begin
         sext_s[i] = ACC_WIDTH'(signed'(psum_in[i]));
         if (pass_cnt_r == 8'd0) begin
            wr_row_s[i] = sext_s[i];
         end else begin
            wr_row_s[i] = mem_r[row_ptr_r][i] + sext_s[i];
         end
      end
      // Row 0 is being written in the same cycle when a tile has one row.
      if (row_ptr_r == {ADDR_WIDTH{1'b0}}) begin
         row0_s = wr_row_s;
      end else begin
         row0_s = mem_r[0];
      end
   end

   // Control conditions shared by the FSM and the datapath.
   always_comb begin
      accept_s      = (state_r == ST_ACCUM) && psum_valid;
      row_wrap_s    = ({1'b0, row_ptr_r} == (rows_r - (ADDR_WIDTH+1)'(1'b1)));
      last_pass_s   = (pass_cnt_r == (passes_r - 8'd1));
      final_write_s = accept_s && row_wrap_s && last_pass_s;
      drain_hs_s    = (state_r == ST_DRAIN) && out_valid && out_ready;
      zero_start_s  = (num_rows == {(ADDR_WIDTH+1){1'b0}}) || (num_passes == 8'd0);
      rd_next_s     = rd_ptr_r + ADDR_WIDTH'(1'b1);
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start && !zero_start_s) begin
               state_nx_s = ST_ACCUM;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (final_write_s) begin
               state_nx_s = ST_DRAIN;
            end else begin
               state_nx_s = ST_ACCUM;
            end
         end
         ST_DRAIN: begin
            if (drain_hs_s && out_last) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Row buffer storage; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_r[row_ptr_r] <= wr_row_s;
      end
   end

   // Pointers, pass counter and registered drain outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         done       <= 1'b0;
         row_ptr_r  <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
         pass_cnt_r <= 8'd0;
         passes_r   <= 8'd0;
         rows_r     <= {(ADDR_WIDTH+1){1'b0}};
         for (int i = 0; i < ARRAY_WIDTH; i++) begin
            out_data[i] <= {ACC_WIDTH{1'b0}};
         end
      end else begin
         busy <= (state_nx_s != ST_IDLE);
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  row_ptr_r  <= {ADDR_WIDTH{1'b0}};
                  rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
                  pass_cnt_r <= 8'd0;
                  rows_r     <= num_rows;
                  passes_r   <= num_passes;
                  done       <= zero_start_s;
               end
            end
            ST_ACCUM: begin
               if (accept_s) begin
                  if (row_wrap_s) begin
                     row_ptr_r  <= {ADDR_WIDTH{1'b0}};
                     pass_cnt_r <= pass_cnt_r + 8'd1;
                  end else begin
                     row_ptr_r <= row_ptr_r + ADDR_WIDTH'(1'b1);
                  end
                  if (final_write_s) begin
                     out_valid <= 1'b1;
                     out_last  <= (rows_r == (ADDR_WIDTH+1)'(1'b1));
                     rd_ptr_r  <= {ADDR_WIDTH{1'b0}};
                     for (int i = 0; i < ARRAY_WIDTH; i++) begin
                        out_data[i] <= relu_lane(row0_s[i]);
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_hs_s) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     rd_ptr_r <= rd_next_s;
                     out_last <= ({1'b0, rd_next_s} == (rows_r - (ADDR_WIDTH+1)'(1'b1)));
                     for (int i = 0; i < ARRAY_WIDTH; i++) begin
                        out_data[i] <= relu_lane(mem_r[rd_next_s][i]);
                     end
                  end
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Scoreboard bench for psum_accum_buffer: stimulus pushes expected rows into a
// queue, a negedge monitor pops and compares on every output handshake.
module tb_psum_accum_buffer;
   localparam int PW   = 32;
   localparam int AW   = 4;
   localparam int ACCW = 40;
   localparam int DEP  = 16;
   localparam int ADW  = 4;

   typedef struct packed {
      logic [AW-1:0][ACCW-1:0] d;
      logic                    last;
   } row_t;

   logic            clk = 1'b0;
   logic            rst, start, psum_valid, out_ready;
   logic [ADW:0]    num_rows;
   logic [7:0]      num_passes;
   logic [PW-1:0]   psum_in [AW];
   logic            busy, out_valid, out_last, done;
   logic [ACCW-1:0] out_data [AW];

   row_t            exp_q [$];
   row_t            exp_r;
   logic [AW-1:0][ACCW-1:0] cur_d, hold_d;
   logic            hold_last;
   bit              hold_v = 1'b0;
   int              errors = 0;
   int              checks = 0;
   int              done_cnt = 0;
   int              done_before;

   psum_accum_buffer #(.PSUM_WIDTH(PW), .ARRAY_WIDTH(AW), .ACC_WIDTH(ACCW), .DEPTH(DEP)) dut (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_passes(num_passes),
      .psum_valid(psum_valid), .psum_in(psum_in), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [ACCW-1:0] relu(input logic signed [ACCW-1:0] v);
`ifdef OUTPUT_ACCUM_RELU_EN
      return (v < 0) ? {ACCW{1'b0}} : v;
`else
      return v;
`endif
   endfunction

   // Monitor: done counting, hold-stability under backpressure, scoreboard pops.
   always @(negedge clk) begin
      for (int i = 0; i < AW; i++) cur_d[i] = out_data[i];
      if (done) done_cnt++;
      if (out_valid && !out_ready) begin
         if (hold_v) begin
            checks++;
            if (cur_d != hold_d || out_last != hold_last) begin
               errors++;
               $display("FAIL hold_stable: got %h/%0b want %h/%0b", cur_d, out_last, hold_d, hold_last);
            end
         end
         hold_v = 1'b1; hold_d = cur_d; hold_last = out_last;
      end else begin
         hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_row: got %h last=%0b, none expected", cur_d, out_last);
         end else begin
            exp_r = exp_q.pop_front();
            if (cur_d != exp_r.d || out_last != exp_r.last) begin
               errors++;
               $display("FAIL row_data: got %h last=%0b want %h last=%0b", cur_d, out_last, exp_r.d, exp_r.last);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input int r, input int p);
      num_rows = r[ADW:0]; num_passes = p[7:0]; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
      psum_valid = 1'b1;
      psum_in[0] = a; psum_in[1] = b; psum_in[2] = c; psum_in[3] = d;
      tick();
      psum_valid = 1'b0;
   endtask

   task automatic bubble();
      psum_valid = 1'b0;
      for (int i = 0; i < AW; i++) psum_in[i] = 32'd99;
      tick();
   endtask

   task automatic push(input logic signed [ACCW-1:0] a, input logic signed [ACCW-1:0] b,
                       input logic signed [ACCW-1:0] c, input logic signed [ACCW-1:0] d, input bit last);
      row_t r;
      r.d[0] = relu(a); r.d[1] = relu(b); r.d[2] = relu(c); r.d[3] = relu(d);
      r.last = last;
      exp_q.push_back(r);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !(exp_q.size() == 0 && !busy); i++) tick();
      check("drain_complete", {63'd0, (exp_q.size() == 0 && !busy)}, 64'd1);
      @(negedge clk); #1;
      check("done_pulses", 64'(done_cnt - done_before), 64'd1);
      tick();
      check("done_low_after", {63'd0, done}, 64'd0);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_busy"}, {63'd0, busy}, 64'd0);
      check({name, "_valid"}, {63'd0, out_valid}, 64'd0);
      check({name, "_last"}, {63'd0, out_last}, 64'd0);
      check({name, "_done"}, {63'd0, done}, 64'd0);
      for (int i = 0; i < AW; i++) check({name, "_data"}, 64'(out_data[i]), 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; psum_valid = 1'b0; out_ready = 1'b1;
      num_rows = '0; num_passes = 8'd0;
      for (int i = 0; i < AW; i++) psum_in[i] = 32'd0;
      tick(); tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      // Single pass, two rows
      done_before = done_cnt;
      do_start(2, 1);
      send(1, 2, 3, 4);
      push(1, 2, 3, 4, 1'b0);
      push(-5, 6, -7, 8, 1'b1);
      send(-5, 6, -7, 8);
      check("first_valid_t1", {63'd0, out_valid}, 64'd1);
      wait_done(20);

      // Multi-pass with bubbles
      done_before = done_cnt;
      do_start(3, 4);
      for (int p = 0; p < 4; p++) begin
         for (int r = 0; r < 3; r++) begin
            if (p == 3 && r == 2) begin
               for (int k = 0; k < 3; k++) push(40, 40, 40, 40, k == 2);
               send(10, 10, 10, 10);
            end else begin
               send(10, 10, 10, 10);
               bubble();
            end
         end
      end
      check("first_valid_t2", {63'd0, out_valid}, 64'd1);
      wait_done(20);

      // Single-row read-after-write hazard
      done_before = done_cnt;
      do_start(1, 5);
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) push(15, 35, 0, -5, 1'b1);
         send(k, 7, 0, -1);
      end
      check("first_valid_t3", {63'd0, out_valid}, 64'd1);
      wait_done(20);

      // Backpressure on row 1
      done_before = done_cnt;
      do_start(3, 2);
      for (int p = 0; p < 2; p++) begin
         for (int r = 0; r < 3; r++) begin
            if (p == 1 && r == 2) begin
               for (int k = 0; k < 3; k++) push(2 * k, 2 * k + 20, -2 * k, 200, k == 2);
            end
            send(r, r + 10, -r, 100);
         end
      end
      check("first_valid_t4", {63'd0, out_valid}, 64'd1);
      tick();
      out_ready = 1'b0;
      repeat (3) tick();
      out_ready = 1'b1;
      wait_done(20);

      // Wide accumulation, sign extension and optional clamp
      done_before = done_cnt;
      do_start(1, 255);
      for (int k = 0; k < 255; k++) begin
         if (k == 254) push(40'sd547608329985, -3, -40'sd547608330240, 255, 1'b1);
         send(32'h7FFF_FFFF, (k == 0) ? -3 : 0, 32'h8000_0000, 1);
      end
      wait_done(20);

      // Reset mid-accumulation, then a fresh tile
      do_start(2, 2);
      send(100, 100, 100, 100);
      send(100, 100, 100, 100);
      send(100, 100, 100, 100);
      rst = 1'b1;
      tick(); tick();
      check_idle_outputs("midrst");
      rst = 1'b0;
      tick();
      done_before = done_cnt;
      do_start(2, 2);
      send(1, 1, 1, 1);
      send(2, 2, 2, 2);
      send(1, 1, 1, 1);
      push(2, 2, 2, 2, 1'b0);
      push(4, 4, 4, 4, 1'b1);
      send(2, 2, 2, 2);
      wait_done(20);

      // Degenerate starts: zero passes and zero rows
      do_start(4, 0);
      check("zero_passes_done", {63'd0, done}, 64'd1);
      check("zero_passes_busy", {63'd0, busy}, 64'd0);
      tick();
      check("zero_passes_done_low", {63'd0, done}, 64'd0);
      do_start(0, 3);
      check("zero_rows_done", {63'd0, done}, 64'd1);
      repeat (3) tick();
      check("zero_start_no_valid", {63'd0, out_valid}, 64'd0);
      check("zero_start_queue", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
